// File: rtl/overlap_frame_scheduler.sv
// overlap_frame_scheduler: 50%-overlap frame reader over a 2N-sample ring buffer
// define FRAME_COUNTER_EN to build the frame_count counter (otherwise it reads 0)
module overlap_frame_scheduler #(
    parameter int WIN_BITS = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                wr_en,
    output logic [WIN_BITS:0]   wr_addr,
    output logic                rd_en,
    output logic [WIN_BITS:0]   rd_addr,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [WIN_BITS-1:0] win_index,
    output logic                frame_start,
    output logic                frame_last,
    output logic [15:0]         frame_count
);
    localparam int AW = WIN_BITS + 1;
    localparam int N = 1 << WIN_BITS;
    localparam int H = N / 2;
    localparam logic [AW:0] OCC_N = (AW+1)'(N);
    localparam logic [AW:0] OCC_H = (AW+1)'(H);
    localparam logic [AW:0] OCC_D = (AW+1)'(2 * N);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, base_q;
    logic [WIN_BITS-1:0]   rd_off_q, win_index_q;
    logic [AW:0]           occ_q, occ_d;
    logic                  out_valid_q, last_issue;
    assign in_ready    = occ_q < OCC_D;
    assign wr_en       = in_valid && in_ready;
    assign wr_addr     = wr_ptr_q;
    assign rd_en       = (state_q == EMIT) && (!out_valid_q || out_ready);
    assign rd_addr     = base_q + AW'(rd_off_q);
    assign last_issue  = rd_en && (rd_off_q == '1);
    assign out_valid   = out_valid_q;
    assign win_index   = win_index_q;
    assign frame_start = out_valid_q && (win_index_q == '0);
    assign frame_last  = out_valid_q && (win_index_q == '1);
    // retiring a frame frees H samples; a same-cycle write still counts
    always_comb begin
        occ_d   = occ_q + (AW+1)'(wr_en) - (last_issue ? OCC_H : '0);
        state_d = (state_q == IDLE) ? ((occ_q >= OCC_N) ? EMIT : IDLE)
                : (last_issue ? ((occ_q >= OCC_N + OCC_H) ? EMIT : IDLE) : EMIT);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            rd_off_q    <= '0;
            occ_q       <= '0;
            out_valid_q <= 1'b0;
            win_index_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_q + AW'(wr_en);
            occ_q       <= occ_d;
            out_valid_q <= rd_en || (out_valid_q && !out_ready);
            if (rd_en) begin
                rd_off_q    <= rd_off_q + WIN_BITS'(1);
                win_index_q <= rd_off_q;
            end
            if (last_issue) base_q <= base_q + AW'(H);
        end
    end
`ifdef FRAME_COUNTER_EN
    logic [15:0] frame_count_q;
    always_ff @(posedge clock) begin
        if (reset) frame_count_q <= '0;
        else if (last_issue) frame_count_q <= frame_count_q + 16'd1;
    end
    assign frame_count = frame_count_q;
`else
    assign frame_count = '0;
`endif
endmodule

// File: tb/tb_overlap_frame_scheduler.sv
// tb_overlap_frame_scheduler: stream-level scoreboard (sample/frame counts) for WIN_BITS=3
module tb_overlap_frame_scheduler;
    localparam int N = 8, H = 4, D = 16;
    logic       clock = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, wr_en, rd_en, out_valid, frame_start, frame_last;
    logic [3:0] wr_addr, rd_addr;
    logic [2:0] win_index;
    logic [15:0] frame_count;
    int n_cmp = 0, n_bad = 0;
    int wr_cnt, frames_m, rd_idx, cyc, first_rd;
    int q[$];

    overlap_frame_scheduler #(.WIN_BITS(3)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
        .out_ready(out_ready), .out_valid(out_valid), .win_index(win_index),
        .frame_start(frame_start), .frame_last(frame_last), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sample k of the stream lives at k mod D; frame f covers samples f*H .. f*H+N-1
    task automatic check_cycle();
        logic exp_ready;
        int   fc;
        int   sidx;
        exp_ready = (wr_cnt - H * frames_m) < D;
`ifdef FRAME_COUNTER_EN
        fc = frames_m & 16'hffff;
`else
        fc = 0;
`endif
        chk("in_ready", in_ready, exp_ready);
        chk("wr_en", wr_en, in_valid && exp_ready);
        chk("wr_addr", wr_addr, wr_cnt % D);
        chk("out_valid", out_valid, q.size() != 0);
        chk("frame_count", frame_count, fc);
        if (q.size() != 0) begin
            chk("win_index", win_index, q[0]);
            chk("frame_start", frame_start, q[0] == 0);
            chk("frame_last", frame_last, q[0] == N - 1);
        end
        if (rd_en === 1'b1) begin
            sidx = frames_m * H + rd_idx;
            if (first_rd < 0) first_rd = cyc;
            chk("rd_during_stall", (q.size() != 0) && !out_ready, 1'b0);
            chk("rd_data_written", sidx < wr_cnt, 1'b1);
            chk("rd_addr", rd_addr, sidx % D);
        end
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (rd_en === 1'b1) begin
            q.push_back(rd_idx);
            rd_idx++;
            if (rd_idx == N) begin
                rd_idx = 0;
                frames_m++;
            end
        end
        if (in_valid && exp_ready) wr_cnt++;
    endtask

    task automatic tick(input logic v, input logic r);
        @(posedge clock);
        #1;
        in_valid  = v;
        out_ready = r;
        cyc++;
        @(negedge clock);
        check_cycle();
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        wr_cnt = 0; frames_m = 0; rd_idx = 0; cyc = 0; first_rd = -1;
        q.delete();
        @(negedge clock);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_occ", dut.occ_q, 0);
        check_cycle();
    endtask

    task automatic run_basic();
        repeat (8) tick(1'b1, 1'b1);
        repeat (10) tick(1'b0, 1'b1);
        chk("basic_first_rd_cycle", first_rd, 10);
        chk("basic_frames", frames_m, 1);
        chk("basic_drained", q.size(), 0);
    endtask

    initial begin
        int found;
        int exp_frames;
        do_reset();
        run_basic();
        // second frame overlaps the first by H samples
        repeat (4) tick(1'b1, 1'b1);
        repeat (12) tick(1'b0, 1'b1);
        chk("f2_frames", frames_m, 2);
        chk("f2_occ", dut.occ_q, 4);
        chk("f2_base", dut.base_q, 8);
        // downstream stall while beat 2 is presented
        repeat (4) tick(1'b1, 1'b1);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            tick(1'b0, 1'b1);
            if (out_valid === 1'b1 && win_index === 3'd1) found = 1;
        end
        chk("stall_reached", found, 1);
        repeat (3) begin
            tick(1'b0, 1'b0);
            chk("stall_rd_en", rd_en, 1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_win_index", win_index, 2);
        end
        repeat (15) tick(1'b0, 1'b1);
        chk("stall_frames", frames_m, 3);
        // fill the ring to capacity with the output blocked, then wrap
        do_reset();
        repeat (20) tick(1'b1, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_wr_addr", wr_addr, 0);
        chk("full_occ", dut.occ_q, 16);
        repeat (80) tick(1'b1, 1'b1);
        chk("wrap_frames_min", frames_m >= 4, 1'b1);
        repeat (40) tick(1'b0, 1'b1);
        // reset in the middle of a frame
        do_reset();
        repeat (8) tick(1'b1, 1'b1);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            tick(1'b0, 1'b1);
            if (out_valid === 1'b1 && win_index === 3'd5) found = 1;
        end
        chk("midreset_reached", found, 1);
        do_reset();
        run_basic();
        // randomized traffic and backpressure
        do_reset();
        for (int i = 0; i < 400; i++) tick(($urandom % 4) != 0, ($urandom % 3) != 0);
        repeat (60) tick(1'b0, 1'b1);
        exp_frames = (wr_cnt >= N) ? (wr_cnt - N) / H + 1 : 0;
        chk("rand_frames", frames_m, exp_frames);
        chk("rand_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
